// File: rtl/jstk2_cursor_pkg.sv
// Shared constants, refresh FSM state encoding and the row-to-ypos encoder
// for the joystick cursor and the OLED screen-builder stages.
// No ports. Pure declarations, no latency and no flow control of its own.
package jstk2_pkg;

  localparam int JSTK_CENTRE = 512;
  localparam int OLED_COLS   = 128;
  localparam int OLED_ROWS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Screen-builder row encoding: page number in the top two bits, then a
  // one-hot mask selecting the pixel bit inside the page byte.
  function automatic logic [9:0] row_to_ypos(input logic [4:0] row);
    logic [7:0] oh;
    oh = 8'd1 << row[2:0];
    return {row[4:3], oh};
  endfunction

endpackage

// File: rtl/jstk2_cursor_if.sv
// Joystick sample bus plus OLED screen-builder EN/FIN handshake and position.
// master: cursor side (drives OLED_EN/xpos/ypos); slave: joystick + screen-builder side.
// Flow control: JSTK_VALID is a plain strobe; OLED_EN/OLED_FIN is a four-phase handshake.
interface jstk2_cursor_if;
  logic [9:0] JSTK_X;
  logic [9:0] JSTK_Y;
  logic       JSTK_VALID;
  logic       OLED_FIN;
  logic       OLED_EN;
  logic [9:0] xpos;
  logic [9:0] ypos;

  modport master (
    input  JSTK_X, JSTK_Y, JSTK_VALID, OLED_FIN,
    output OLED_EN, xpos, ypos
  );

  modport slave (
    output JSTK_X, JSTK_Y, JSTK_VALID, OLED_FIN,
    input  OLED_EN, xpos, ypos
  );
endinterface

// File: rtl/jstk2_cursor_step_timer.sv
// Free-running divider: one-cycle tick every DIV clocks (counter 0..DIV-1).
// Ports: CLK, RST (async active-low), tick out. First tick DIV-1 cycles after reset.
// No backpressure: tick is unconditional and is never held off.
module step_timer #(
  parameter int DIV = 1200000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick  = (cnt_q == W'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jstk2_cursor.sv
// Joystick-driven saturating cursor for the 128x32 OLED, with EN/FIN refresh launch.
// Ports: CLK, RST (async active-low), bus (master): JSTK_X/Y/VALID, OLED_FIN in; OLED_EN, xpos, ypos out.
// Latency: tick -> col/row +1, -> OLED_EN with new xpos/ypos +2. Refresh waits while OLED_FIN is high.
module jstk2_cursor
  import jstk2_pkg::*;
#(
  parameter int DEADZONE = 64,
  parameter int STEP_DIV = 1200000,
  parameter int X_INIT   = 64,
  parameter int Y_INIT   = 16
) (
  input  logic           CLK,
  input  logic           RST,
  jstk2_cursor_if.master bus
);

  localparam logic [1:0]  S_IDLE = ST_IDLE;
  localparam logic [1:0]  S_REQ  = ST_REQ;
  localparam logic [1:0]  S_DROP = ST_DROP;
  localparam logic [6:0]  X0     = 7'(X_INIT);
  localparam logic [4:0]  Y0     = 5'(Y_INIT);
  localparam logic [10:0] DZ_LO  = 11'(JSTK_CENTRE - DEADZONE);
  localparam logic [10:0] DZ_HI  = 11'(JSTK_CENTRE - 1 + DEADZONE);
  localparam logic [7:0]  COL_MAX = 8'(OLED_COLS - 1);
  localparam logic [7:0]  ROW_MAX = 8'(OLED_ROWS - 1);

  logic       tick;
  logic [9:0] smp_x_q, smp_y_q;
  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [1:0] state_q, state_d;
  logic       en_q, en_d;
  logic       dirty_q, dirty_d;
  logic [9:0] xpos_q, xpos_d;
  logic [9:0] ypos_q, ypos_d;
  logic [1:0] dx, drow;
  logic [7:0] col_sum, row_sum;
  logic       differ, launch;

  step_timer #(.DIV(STEP_DIV)) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  // Two-bit signed steps. Stick up is +1 on the Y axis, which moves the
  // cursor towards row 0, so drow carries the already-negated row step.
  always_comb begin
    dx   = 2'b00;
    drow = 2'b00;
    if ({1'b0, smp_x_q} < DZ_LO)      dx = 2'b11;
    else if ({1'b0, smp_x_q} > DZ_HI) dx = 2'b01;
    if ({1'b0, smp_y_q} < DZ_LO)      drow = 2'b01;
    else if ({1'b0, smp_y_q} > DZ_HI) drow = 2'b11;
  end

  assign col_sum = {1'b0, col_q} + {{6{dx[1]}}, dx};
  assign row_sum = {3'b0, row_q} + {{6{drow[1]}}, drow};

  // 0 - 1 shows up as bit 7 set; for the column, 127 + 1 = 128 also sets
  // bit 7, so the low clamp is qualified by the step being negative.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (tick) begin
      if (dx[1] && col_sum[7])   col_d = 7'd0;
      else if (col_sum > COL_MAX) col_d = COL_MAX[6:0];
      else                        col_d = col_sum[6:0];
      if (row_sum[7])             row_d = 5'd0;
      else if (row_sum > ROW_MAX) row_d = ROW_MAX[4:0];
      else                        row_d = row_sum[4:0];
    end
  end

  // Compared directly against the displayed outputs so a cursor change is
  // seen in the same cycle, giving the tick -> EN latency of two cycles.
  assign differ = (xpos_q[9:3] != col_q) || (ypos_q != row_to_ypos(row_q));

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((dirty_q || differ) && !bus.OLED_FIN) begin
          launch  = 1'b1;
          state_d = S_REQ;
          en_d    = 1'b1;
          xpos_d  = {col_q, 3'b000};
          ypos_d  = row_to_ypos(row_q);
        end
      end
      S_REQ: begin
        if (bus.OLED_FIN) begin
          en_d    = 1'b0;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (!bus.OLED_FIN) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  assign dirty_d = launch ? 1'b0 : (dirty_q | differ);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp_x_q <= 10'(JSTK_CENTRE);
      smp_y_q <= 10'(JSTK_CENTRE);
      col_q   <= X0;
      row_q   <= Y0;
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      dirty_q <= 1'b1;
      xpos_q  <= {X0, 3'b000};
      ypos_q  <= row_to_ypos(Y0);
    end else begin
      if (bus.JSTK_VALID) begin
        smp_x_q <= bus.JSTK_X;
        smp_y_q <= bus.JSTK_Y;
      end
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      en_q    <= en_d;
      dirty_q <= dirty_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
    end
  end

  assign bus.OLED_EN = en_q;
  assign bus.xpos    = xpos_q;
  assign bus.ypos    = ypos_q;

endmodule

// File: tb/tb_jstk2_cursor.sv
// Testbench for jstk2_cursor with STEP_DIV=4: reset defaults, table of stick moves,
// mid-refresh motion and reset during an outstanding refresh request.
// The screen-builder is either auto-answered (FIN follows EN) or driven by hand.
module tb_jstk2_cursor;

  logic clk;
  logic rst_n;
  logic auto_on;
  logic fin_man;
  logic fin_auto;

  jstk2_cursor_if bus ();

  assign bus.OLED_FIN = auto_on ? fin_auto : fin_man;

  jstk2_cursor #(
    .DEADZONE (64),
    .STEP_DIV (4),
    .X_INIT   (64),
    .Y_INIT   (16)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; with STEP_DIV=4 a tick lands on every edge
  // that takes k from 3 mod 4 to 0 mod 4.
  int k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  always @(negedge clk) fin_auto <= bus.OLED_EN;

  // Refresh monitor: captures the payload of each EN rising edge and counts
  // output changes that happen anywhere other than a refresh launch.
  int         refresh_cnt = 0;
  int         stab_err = 0;
  logic       en_prev = 1'b0;
  logic       rst_prev = 1'b0;
  logic [9:0] last_x = '0, last_y = '0, px = '0, py = '0;
  always @(negedge clk) begin
    if (bus.OLED_EN && !en_prev) begin
      refresh_cnt <= refresh_cnt + 1;
      last_x      <= bus.xpos;
      last_y      <= bus.ypos;
    end
    if (rst_n && rst_prev && !(bus.OLED_EN && !en_prev) &&
        ((bus.xpos != px) || (bus.ypos != py)))
      stab_err <= stab_err + 1;
    en_prev  <= bus.OLED_EN;
    rst_prev <= rst_n;
    px       <= bus.xpos;
    py       <= bus.ypos;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic wait_phase0();
    @(negedge clk);
    while ((k % 4) != 0) @(negedge clk);
  endtask

  typedef struct {
    logic [9:0] jx;
    logic [9:0] jy;
    int         n;
    logic [9:0] ex;
    logic [9:0] ey;
    bit         moves;
  } vec_t;

  typedef struct {
    logic [9:0] ex;
    logic [9:0] ey;
    bit         moves;
    int         base;
    int         idx;
  } exp_t;

  vec_t vt[12];
  exp_t sb[$];

  initial begin
    exp_t e;
    bit   en_seen;

    // Cursor starts at col 64, row 16 (page 2, pixel 0).
    vt[0]  = '{10'd1023, 10'd512,  70,  10'h3F8, 10'h201, 1'b1}; // saturate right
    vt[1]  = '{10'd1023, 10'd512,  5,   10'h3F8, 10'h201, 1'b0}; // pinned at 127
    vt[2]  = '{10'd512,  10'd1000, 20,  10'h3F8, 10'h001, 1'b1}; // up to row 0
    vt[3]  = '{10'd512,  10'd1000, 5,   10'h3F8, 10'h001, 1'b0}; // pinned at row 0
    vt[4]  = '{10'd512,  10'd10,   9,   10'h3F8, 10'h102, 1'b1}; // down to row 9
    vt[5]  = '{10'd0,    10'd512,  200, 10'h000, 10'h102, 1'b1}; // saturate left
    vt[6]  = '{10'd0,    10'd512,  3,   10'h000, 10'h102, 1'b0}; // pinned at 0
    vt[7]  = '{10'd575,  10'd449,  20,  10'h000, 10'h102, 1'b0}; // inside dead zone
    vt[8]  = '{10'd576,  10'd512,  1,   10'h008, 10'h102, 1'b1}; // first +1 count
    vt[9]  = '{10'd447,  10'd576,  1,   10'h000, 10'h101, 1'b1}; // first -1, up
    vt[10] = '{10'd1023, 10'd10,   3,   10'h018, 10'h108, 1'b1}; // diagonal
    vt[11] = '{10'd448,  10'd575,  10,  10'h018, 10'h108, 1'b0}; // band edges

    rst_n          = 1'b0;
    auto_on        = 1'b0;
    fin_man        = 1'b0;
    bus.JSTK_VALID = 1'b1;
    bus.JSTK_X     = 10'd512;
    bus.JSTK_Y     = 10'd512;

    // Reset defaults and the first refresh.
    repeat (3) @(negedge clk);
    chk("reset_en",   32'(bus.OLED_EN), 32'd0);
    chk("reset_xpos", 32'(bus.xpos), 32'h200);
    chk("reset_ypos", 32'(bus.ypos), 32'h201);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_en",   32'(bus.OLED_EN), 32'd1);
    chk("first_xpos", 32'(bus.xpos), 32'h200);
    chk("first_ypos", 32'(bus.ypos), 32'h201);
    fin_man = 1'b1;
    @(negedge clk);
    chk("first_en_drop", 32'(bus.OLED_EN), 32'd0);
    fin_man = 1'b0;
    repeat (2) @(negedge clk);
    auto_on = 1'b1;

    // Table vectors: deflect for exactly n ticks, recentre, let it settle.
    for (int i = 0; i < 12; i++) begin
      wait_phase0();
      e.ex = vt[i].ex; e.ey = vt[i].ey; e.moves = vt[i].moves;
      e.base = refresh_cnt; e.idx = i;
      sb.push_back(e);
      bus.JSTK_X = vt[i].jx;
      bus.JSTK_Y = vt[i].jy;
      repeat (4 * vt[i].n) @(negedge clk);
      bus.JSTK_X = 10'd512;
      bus.JSTK_Y = 10'd512;
      repeat (40) @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d_xpos", e.idx), 32'(last_x), 32'(e.ex));
      chk($sformatf("vec%0d_ypos", e.idx), 32'(last_y), 32'(e.ey));
      if (e.moves) chk($sformatf("vec%0d_refreshed", e.idx), 32'(refresh_cnt > e.base), 32'd1);
      else         chk($sformatf("vec%0d_refreshes", e.idx), 32'(refresh_cnt - e.base), 32'd0);
    end

    // Mid-refresh motion: two ticks land while the first request is held.
    auto_on = 1'b0;
    fin_man = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    bus.JSTK_X = 10'd1023;
    for (int c = 0; c < 20 && k != 8; c++) @(negedge clk);
    bus.JSTK_X = 10'd512;
    chk("mid_k_reached", 32'(k), 32'd8);
    chk("mid_en_held",   32'(bus.OLED_EN), 32'd1);
    chk("mid_xpos_held", 32'(bus.xpos), 32'h200);
    fin_man = 1'b1;
    @(negedge clk);
    chk("mid_en_drop", 32'(bus.OLED_EN), 32'd0);
    fin_man = 1'b0;
    for (int c = 0; c < 20 && !bus.OLED_EN; c++) @(negedge clk);
    chk("mid_second_en",   32'(bus.OLED_EN), 32'd1);
    chk("mid_second_xpos", 32'(bus.xpos), 32'h210);
    chk("mid_second_ypos", 32'(bus.ypos), 32'h201);

    // Reset while the second request is outstanding.
    rst_n = 1'b0;
    #1;
    chk("rstreq_en",   32'(bus.OLED_EN), 32'd0);
    chk("rstreq_xpos", 32'(bus.xpos), 32'h200);
    chk("rstreq_ypos", 32'(bus.ypos), 32'h201);
    fin_man = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    en_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      en_seen = en_seen | bus.OLED_EN;
    end
    chk("rstreq_en_blocked", 32'(en_seen), 32'd0);
    fin_man = 1'b0;
    for (int c = 0; c < 10 && !bus.OLED_EN; c++) @(negedge clk);
    chk("rstreq_en_after_fin", 32'(bus.OLED_EN), 32'd1);
    chk("rstreq_xpos_after",   32'(bus.xpos), 32'h200);
    fin_man = 1'b1;
    @(negedge clk);
    fin_man = 1'b0;
    repeat (4) @(negedge clk);

    chk("output_stability", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jstk2_cursor.md
# jstk2_cursor

Converts PmodJSTK2 joystick samples into a saturating pixel cursor on the 128x32 PmodOLED and drives the OLED screen-builder's EN/FIN handshake. It sits directly upstream of the OLED screen-builder. It supplies `xpos`/`ypos` in that stage's encoding and holds them stable for the whole of each refresh, so a redraw never sees a half-updated position.

## Interface
Parameters:
- `DEADZONE`, 64: half-width of the joystick centre band, in raw counts around 512.
- `STEP_DIV`, 1200000: clock cycles per cursor step (100 ms at 12 MHz).
- `X_INIT`, 64: column (0..127) after reset.
- `Y_INIT`, 16: row (0..31) after reset.

Ports:
- `CLK` in 1: system clock.
- `RST` in 1: reset, asynchronous, active-low.
- `JSTK_X` in 10: raw joystick X, 0..1023, centre 512.
- `JSTK_Y` in 10: raw joystick Y, 0..1023, centre 512; high = stick up.
- `JSTK_VALID` in 1: one-cycle strobe qualifying `JSTK_X`/`JSTK_Y`.
- `OLED_FIN` in 1: screen-builder done flag.
- `OLED_EN` out 1: refresh request to the screen-builder.
- `xpos` out 10: displayed column, encoded as {col[6:0], 3'b000}.
- `ypos` out 10: displayed row, encoded as {row[4:3], one-hot(row[2:0])}, where bit k set means pixel k of the page byte.

## Operation
- **Sample latch.** On `JSTK_VALID`, `JSTK_X`/`JSTK_Y` are registered into `smp_x`/`smp_y`. Reset value of both is 512.
- **Direction decode per axis**, 2-bit signed step:
  - -1 if `smp < 512-DEADZONE`
  - +1 if `smp > 511+DEADZONE`
  - else 0
  - X: +1 moves right.
  - Y: +1 (stick up) decrements the row; row 0 is the top line.
- **Step timer.** A free-running counter runs 0..`STEP_DIV`-1. It asserts `tick` for one cycle at the wrap.
- **Cursor update on `tick`.**
  - `col += dx`, saturating at 0 and 127.
  - `row += dy`, saturating at 0 and 31.
  - No wrap-around.
  - Arithmetic is done at 8 bits before clamping.
- **Dirty flag.**
  - Set at reset.
  - Set whenever the cursor (`col`,`row`) differs from the displayed pair.
  - Cleared when a refresh is launched.
- **Refresh FSM**, states IDLE, REQ, DROP:
  - IDLE: if dirty and `OLED_FIN`=0, copy the cursor into `xpos`/`ypos`, set `OLED_EN`=1, go to REQ.
  - REQ: hold `OLED_EN`=1; on `OLED_FIN`=1, set `OLED_EN`=0 and go to DROP.
  - DROP: wait for `OLED_FIN`=0, then go to IDLE.
- **Output stability.** `xpos`/`ypos` change only on the IDLE→REQ transition. Cursor steps during REQ/DROP update `col`/`row` only and re-set dirty, which triggers a follow-up refresh.
- **Reset values:**
  - `OLED_EN`=0, FSM=IDLE, dirty=1, timer=0.
  - `col`=`X_INIT`, `row`=`Y_INIT`.
  - `xpos`={`X_INIT`,3'b0}, `ypos`={`Y_INIT`[4:3], one-hot(`Y_INIT`[2:0])}.
- **Reset mid-refresh.** `OLED_EN` drops asynchronously. After reset release the block re-enters IDLE with dirty=1, so the first refresh waits until `OLED_FIN`=0.

## Timing
- `JSTK_VALID` at cycle t: the sample is usable by a tick at t+1 or later. A simultaneous VALID and tick uses the previous sample.
- Tick at cycle t: `col`/`row` are updated at t+1. If in IDLE, `OLED_EN` and the new `xpos`/`ypos` appear at t+2, on the same edge.
- `OLED_FIN` rising at cycle t: `OLED_EN` falls at t+1.
- Minimum spacing between `OLED_EN` rising edges is 3 cycles plus the downstream busy time.
- With the stick centred and no change pending, `OLED_EN` stays 0 indefinitely after the first refresh.

## Structure
- **Shared package `jstk2_pkg`:**
  - `JSTK_CENTRE`=512
  - `OLED_COLS`=128
  - `OLED_ROWS`=32
  - FSM state enum (IDLE/REQ/DROP)
  - function `row_to_ypos(row[4:0])` returning 10 bits
- **Sub-module `step_timer`** (`DIV` parameter; `CLK`, `RST`, `tick` out), reusable for other rate-limited stages.
- Everything else stays flat in `jstk2_cursor`.

## Test plan
- **Reset release, `OLED_FIN`=0, defaults:** `xpos`=0x200, `ypos`=0x201 (page 2, row 0). `OLED_EN` rises 1 cycle after release. Respond with FIN=1 → EN falls next cycle.
- **Stick full right** (`JSTK_X`=1023, Y=512), `STEP_DIV`=4, 70 ticks with handshakes auto-answered: `col` saturates at 127, `xpos`=0x3F8, and no further `OLED_EN` occurs once 127 is displayed.
- **Stick up** (`JSTK_Y`=1000) from row 0: row stays 0 and no refresh follows. Then stick down (`JSTK_Y`=10) for 9 ticks: row=9, `ypos`=0x102.
- **Dead zone:** `JSTK_X`=575, `JSTK_Y`=449 over 20 ticks → no cursor movement, `OLED_EN` stays 0. `JSTK_X`=576 → col+1 on the next tick.
- **Mid-refresh motion:** hold `OLED_FIN`=0 during REQ while two ticks move col 64→66. `xpos` stays 0x200 until the handshake completes. A second refresh then shows `xpos`=0x210.
- **Reset asserted during REQ:** `OLED_EN`=0 immediately and all outputs return to reset values. After release, with `OLED_FIN` held 1, `OLED_EN` stays 0 until FIN=0.
